// File: rtl/bank_arb_resp_demux_pkg.sv
// Shared helpers for the bank arbiter / response demux slice.
// Holds only constant functions; all types live in the modules themselves.
package bank_arb_resp_demux_pkg;

  // Index width for n masters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_arb_resp_demux_rr_arb.sv
// Pointer-based round-robin arbiter: the winner is the first request at or
// above rr_q (wrapping), and the pointer moves past the winner on handshake.
module bank_rr_arb
  import bank_arb_resp_demux_pkg::*;
#(
  parameter int unsigned NumIn = 4,
  parameter int unsigned IdxW  = idx_width(NumIn)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] req_i,
  input  logic             hs_i,
  output logic [IdxW-1:0]  idx_o
);

  localparam int unsigned CntW = IdxW + 1;

  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] idx_inc;
  logic [CntW-1:0] cand;
  logic            found;

  // Candidates are formed with a conditional subtract so NumIn need not be 2^n.
  always_comb begin
    idx_o = rr_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NumIn; i++) begin
      cand = {1'b0, rr_q} + CntW'(i);
      if (cand >= CntW'(NumIn)) begin
        cand = cand - CntW'(NumIn);
      end
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    idx_inc = idx_o + IdxW'(1);
    if (idx_o == IdxW'(NumIn - 1)) begin
      idx_inc = '0;
    end
    rr_d = hs_i ? idx_inc : rr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/bank_arb_resp_demux.sv
// Arbitrates many masters onto one memory bank and routes each response
// back to the granted master after a fixed bank latency.
module bank_arb_resp_demux
  import bank_arb_resp_demux_pkg::*;
#(
  parameter int unsigned NumIn         = 32,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter logic        WriteRespOn   = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumIn-1:0]               req_i,
  input  logic [NumIn-1:0]               wen_i,
  input  logic [NumIn*ReqDataWidth-1:0]  data_i,
  output logic [NumIn-1:0]               gnt_o,
  output logic [NumIn-1:0]               vld_o,
  output logic [NumIn*RespDataWidth-1:0] rdata_o,
  output logic                           req_o,
  input  logic                           gnt_i,
  output logic                           wen_o,
  output logic [ReqDataWidth-1:0]        data_o,
  input  logic [RespDataWidth-1:0]       rdata_i
);

  localparam int unsigned IdxW = idx_width(NumIn);

  if (NumIn == 0 || RespLat == 0) begin : g_bad_cfg
    $fatal(1, "bank_arb_resp_demux: NumIn and RespLat must be non-zero");
  end

  logic                           hs;
  logic                           resp_v;
  logic [IdxW-1:0]                idx;
  logic [RespLat-1:0]             vld_pipe_q, vld_pipe_d;
  logic [RespLat-1:0][IdxW-1:0]   idx_pipe_q, idx_pipe_d;

  assign req_o  = |req_i;
  assign hs     = req_o & gnt_i;
  assign resp_v = hs & (~wen_o | WriteRespOn);

  if (NumIn == 1) begin : g_single
    assign idx = '0;
  end else begin : g_arb
    bank_rr_arb #(
      .NumIn (NumIn),
      .IdxW  (IdxW)
    ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (req_i),
      .hs_i   (hs),
      .idx_o  (idx)
    );
  end

  always_comb begin
    wen_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (idx == IdxW'(i)) begin
        wen_o  = wen_i[i];
        data_o = data_i[i*ReqDataWidth +: ReqDataWidth];
      end
    end
  end

  // Stage 0 captures this cycle's handshake; the last stage drives vld_o.
  always_comb begin
    vld_pipe_d    = '0;
    idx_pipe_d    = '0;
    vld_pipe_d[0] = resp_v;
    idx_pipe_d[0] = idx;
    for (int i = 1; i < RespLat; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      idx_pipe_d[i] = idx_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
    end
  end

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_port
    assign gnt_o[gi] = gnt_i & req_i[gi] & (idx == IdxW'(gi));
    assign vld_o[gi] = vld_pipe_q[RespLat-1] & (idx_pipe_q[RespLat-1] == IdxW'(gi));
    assign rdata_o[gi*RespDataWidth +: RespDataWidth] = rdata_i;
  end

endmodule

// File: tb/tb_bank_arb_resp_demux.sv
// Directed bench for bank_arb_resp_demux across several parameter sets,
// each instance exercised in turn with hand-computed expectations.
module tb_bank_arb_resp_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_v, wen_v;
  logic [31:0] data_v;
  logic        gnt_v;
  logic [7:0]  rdata_v;

  logic [3:0]  gnt_a, vld_a;   logic [31:0] rdata_a; logic req_a, wen_a; logic [7:0] dat_a;
  logic [2:0]  gnt_b, vld_b;   logic [23:0] rdata_b; logic req_b, wen_b; logic [7:0] dat_b;
  logic [3:0]  gnt_c, vld_c;   logic [31:0] rdata_c; logic req_c, wen_c; logic [7:0] dat_c;
  logic [3:0]  gnt_d, vld_d;   logic [31:0] rdata_d; logic req_d, wen_d; logic [7:0] dat_d;
  logic        gnt_e, vld_e;   logic [7:0]  rdata_e; logic req_e, wen_e; logic [7:0] dat_e;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(8), .RespDataWidth(8), .RespLat(1), .WriteRespOn(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_v), .wen_i(wen_v), .data_i(data_v),
    .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_a), .req_o(req_a), .gnt_i(gnt_v),
    .wen_o(wen_a), .data_o(dat_a), .rdata_i(rdata_v));

  bank_arb_resp_demux #(.NumIn(3), .ReqDataWidth(8), .RespDataWidth(8), .RespLat(1), .WriteRespOn(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[2:0]), .wen_i(wen_v[2:0]), .data_i(data_v[23:0]),
    .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_b), .req_o(req_b), .gnt_i(gnt_v),
    .wen_o(wen_b), .data_o(dat_b), .rdata_i(rdata_v));

  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(8), .RespDataWidth(8), .RespLat(3), .WriteRespOn(1'b0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_v), .wen_i(wen_v), .data_i(data_v),
    .gnt_o(gnt_c), .vld_o(vld_c), .rdata_o(rdata_c), .req_o(req_c), .gnt_i(gnt_v),
    .wen_o(wen_c), .data_o(dat_c), .rdata_i(rdata_v));

  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(8), .RespDataWidth(8), .RespLat(2), .WriteRespOn(1'b1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_v), .wen_i(wen_v), .data_i(data_v),
    .gnt_o(gnt_d), .vld_o(vld_d), .rdata_o(rdata_d), .req_o(req_d), .gnt_i(gnt_v),
    .wen_o(wen_d), .data_o(dat_d), .rdata_i(rdata_v));

  bank_arb_resp_demux #(.NumIn(1), .ReqDataWidth(8), .RespDataWidth(8), .RespLat(2), .WriteRespOn(1'b1)) u_e (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_v[0]), .wen_i(wen_v[0]), .data_i(data_v[7:0]),
    .gnt_o(gnt_e), .vld_o(vld_e), .rdata_o(rdata_e), .req_o(req_e), .gnt_i(gnt_v),
    .wen_o(wen_e), .data_o(dat_e), .rdata_i(rdata_v));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Leaves time at posedge+1, so inputs change and outputs settle off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_v = '0;
    wen_v = '0;
    gnt_v = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int exp_gnt36 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  int exp_vld36 [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int gnt41     [7] = '{1, 0, 1, 1, 0, 0, 0};
  int exp_vld41 [7] = '{0, 0, 1, 0, 1, 1, 0};

  initial begin
    rst_n   = 1'b0;
    req_v   = '0;
    wen_v   = '0;
    gnt_v   = 1'b0;
    data_v  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rdata_v = 8'h5A;

    // Reset state and combinational replication
    #1;
    chk("rst_vld_a", vld_a, 0);
    chk("rst_vld_c", vld_c, 0);
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_req_a", req_a, 0);
    chk("rdata_a", rdata_a, 32'h5A5A5A5A);
    chk("rdata_b", rdata_b, 24'h5A5A5A);
    chk("rdata_d", rdata_d, 32'h5A5A5A5A);
    chk("rdata_e", rdata_e, 8'h5A);

    // Full contention, one grant per cycle in rotation
    do_reset();
    req_v = 4'b1111;
    gnt_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) req_v = 4'b0000;
      #1;
      chk($sformatf("rot_gnt%0d", i), gnt_a, exp_gnt36[i]);
      chk($sformatf("rot_vld%0d", i), vld_a, exp_vld36[i]);
      if (i < 4) chk($sformatf("rot_dat%0d", i), dat_a, 8'hA0 + i);
      tick();
    end

    // Stalled winner keeps its slot; next grant goes to master 3 (write, still responds)
    do_reset();
    req_v = 4'b1010;
    wen_v = 4'b1010;
    gnt_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_gnt%0d", i), gnt_a, 0);
      chk($sformatf("stall_req%0d", i), req_a, 1);
      chk($sformatf("stall_vld%0d", i), vld_a, 0);
      tick();
    end
    gnt_v = 1'b1;
    #1;
    chk("stall_gnt_go", gnt_a, 4'b0010);
    chk("stall_dat_go", dat_a, 8'hA1);
    chk("stall_wen_go", wen_a, 1);
    tick();
    #1;
    chk("next_gnt_m3", gnt_a, 4'b1000);
    chk("next_vld_m1", vld_a, 4'b0010);
    tick();
    req_v = 4'b0000;
    #1;
    chk("wr_resp_vld_m3", vld_a, 4'b1000);
    tick();

    // Withdrawn request gets no response and does not move the pointer
    do_reset();
    req_v = 4'b0100;
    gnt_v = 1'b0;
    #1;
    chk("wd_gnt0", gnt_a, 0);
    tick();
    req_v = 4'b0000;
    gnt_v = 1'b1;
    #1;
    chk("wd_gnt1", gnt_a, 0);
    chk("wd_req1", req_a, 0);
    tick();
    req_v = 4'b0101;
    #1;
    chk("wd_vld2", vld_a, 0);
    chk("wd_ptr_gnt", gnt_a, 4'b0001);
    tick();

    // NumIn=3 wraparound from pointer 2
    do_reset();
    wen_v = 4'b0000;
    req_v = 4'b0010;
    gnt_v = 1'b1;
    #1;
    chk("w3_gnt_m1", gnt_b, 3'b010);
    chk("w3_dat_m1", dat_b, 8'hA1);
    chk("w3_req", req_b, 1);
    chk("w3_wen", wen_b, 0);
    tick();
    req_v = 4'b0001;
    #1;
    chk("w3_gnt_wrap", gnt_b, 3'b001);
    chk("w3_vld_m1", vld_b, 3'b010);
    tick();
    req_v = 4'b0111;
    #1;
    chk("w3_gnt_ptr1", gnt_b, 3'b010);
    chk("w3_vld_m0", vld_b, 3'b001);
    tick();

    // RespLat=3, writes silent: read m1, write m2, read m0
    do_reset();
    gnt_v = 1'b1;
    req_v = 4'b0010; wen_v = 4'b0000;
    #1;
    chk("l3_gnt_t0", gnt_c, 4'b0010);
    chk("l3_dat_t0", dat_c, 8'hA1);
    tick();
    req_v = 4'b0100; wen_v = 4'b0100;
    #1;
    chk("l3_gnt_t1", gnt_c, 4'b0100);
    chk("l3_wen_t1", wen_c, 1);
    chk("l3_vld_t1", vld_c, 0);
    tick();
    req_v = 4'b0001; wen_v = 4'b0000;
    #1;
    chk("l3_gnt_t2", gnt_c, 4'b0001);
    chk("l3_req_t2", req_c, 1);
    chk("l3_vld_t2", vld_c, 0);
    tick();
    req_v = 4'b0000;
    #1;
    chk("l3_vld_t3", vld_c, 4'b0010);
    chk("l3_rdata_t3", rdata_c, 32'h5A5A5A5A);
    tick();
    #1;
    chk("l3_vld_t4", vld_c, 4'b0000);
    tick();
    #1;
    chk("l3_vld_t5", vld_c, 4'b0001);
    tick();
    #1;
    chk("l3_vld_t6", vld_c, 4'b0000);

    // RespLat=2: reset right after a handshake discards the response
    do_reset();
    req_v = 4'b0001;
    gnt_v = 1'b1;
    #1;
    chk("rl_gnt_t0", gnt_d, 4'b0001);
    tick();
    rst_n = 1'b0;
    req_v = 4'b0000;
    #1;
    chk("rl_vld_t1", vld_d, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rl_vld_t2", vld_d, 0);
    tick();
    #1;
    chk("rl_vld_t3", vld_d, 0);
    req_v = 4'b0011;
    #1;
    chk("rl_gnt_ptr0", gnt_d, 4'b0001);
    chk("rl_dat", dat_d, 8'hA0);
    chk("rl_wen", wen_d, 0);
    chk("rl_req", req_d, 1);
    tick();

    // NumIn=1 pass-through with toggling bank grant
    do_reset();
    req_v = 4'b0001;
    wen_v = 4'b0000;
    #1;
    chk("n1_req", req_e, 1);
    chk("n1_dat", dat_e, 8'hA0);
    chk("n1_wen", wen_e, 0);
    for (int i = 0; i < 7; i++) begin
      gnt_v = gnt41[i][0];
      #1;
      chk($sformatf("n1_gnt%0d", i), gnt_e, gnt41[i]);
      chk($sformatf("n1_vld%0d", i), vld_e, exp_vld41[i]);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
